// File: rtl/demux_1x2_16bit_buf_pkg.sv
// Shared definitions for the 1x2 buffered demultiplexer: data width, queue depth,
// and the pointer/occupancy types used by the per-destination FIFOs.
package demux_1x2_16bit_buf_pkg;

   localparam int unsigned DATA_W_DEF  = 16;
   localparam int unsigned QUEUE_DEPTH = 2;
   localparam int unsigned PTR_W       = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int unsigned OCC_W       = $clog2(QUEUE_DEPTH + 1);
   localparam int unsigned CNT_W       = 16;

   typedef logic [PTR_W-1:0] ptr_t;
   typedef logic [OCC_W-1:0] occ_t;
   typedef logic [CNT_W-1:0] cnt_t;

   // Circular increment, so a non-power-of-two depth still wraps correctly.
   function automatic ptr_t ptr_inc(input ptr_t p);
      return (p == ptr_t'(QUEUE_DEPTH - 1)) ? ptr_t'(0) : ptr_t'(p + ptr_t'(1));
   endfunction

endpackage

// File: rtl/demux_1x2_16bit_buf_fifo2_16bit.sv
// Small synchronous FIFO with a registered head word that holds its last value
// once the queue drains.
module fifo2_16bit
   import demux_1x2_16bit_buf_pkg::*;
#(
   parameter int unsigned WIDTH = DATA_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   logic [WIDTH-1:0] mem_q [QUEUE_DEPTH];
   logic [WIDTH-1:0] mem_d [QUEUE_DEPTH];
   logic [WIDTH-1:0] head_q, head_d;
   ptr_t             rd_ptr_q, rd_ptr_d;
   ptr_t             wr_ptr_q, wr_ptr_d;
   occ_t             occ_q, occ_d;
   logic             do_push, do_pop;

   always_comb begin
      do_push  = push && (occ_q != occ_t'(QUEUE_DEPTH));
      do_pop   = pop && (occ_q != occ_t'(0));
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      occ_d    = occ_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = ptr_inc(wr_ptr_q);
      end
      if (do_pop) begin
         rd_ptr_d = ptr_inc(rd_ptr_q);
      end
      unique case ({do_push, do_pop})
         2'b10:   occ_d = occ_q + occ_t'(1);
         2'b01:   occ_d = occ_q - occ_t'(1);
         default: occ_d = occ_q;
      endcase
      // Head is the post-update entry at the read pointer; hold when drained.
      head_d = (occ_d != occ_t'(0)) ? mem_d[rd_ptr_d] : head_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < int'(QUEUE_DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         head_q   <= '0;
         rd_ptr_q <= '0;
         wr_ptr_q <= '0;
         occ_q    <= '0;
      end else begin
         mem_q    <= mem_d;
         head_q   <= head_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         occ_q    <= occ_d;
      end
   end

   assign full  = (occ_q == occ_t'(QUEUE_DEPTH));
   assign empty = (occ_q == occ_t'(0));
   assign head  = head_q;

endmodule

// File: rtl/demux_1x2_16bit_buf.sv
// 1-to-2 demultiplexer with a small FIFO per destination and per-destination
// accepted-word counters.
module demux_1x2_16bit_buf
   import demux_1x2_16bit_buf_pkg::*;
#(
   parameter int unsigned DATA_W = DATA_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_sel,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] out0_data,
   output logic              out0_valid,
   input  logic              out0_ready,
   output logic [DATA_W-1:0] out1_data,
   output logic              out1_valid,
   input  logic              out1_ready,
   output logic [15:0]       cnt0,
   output logic [15:0]       cnt1
);

   logic full0, full1, empty0, empty1;
   logic push, push0, push1, pop0, pop1;
   cnt_t cnt0_q, cnt1_q;

   // Readiness looks only at the selected queue's registered occupancy.
   always_comb begin
      in_ready = !rst && !(in_sel ? full1 : full0);
      push     = in_valid && in_ready;
      push0    = push && !in_sel;
      push1    = push && in_sel;
      pop0     = out0_ready && !empty0;
      pop1     = out1_ready && !empty1;
   end

   fifo2_16bit #(
      .WIDTH(DATA_W)
   ) u_fifo0 (
      .clk      (clk),
      .rst      (rst),
      .push     (push0),
      .push_data(in_data),
      .pop      (pop0),
      .full     (full0),
      .empty    (empty0),
      .head     (out0_data)
   );

   fifo2_16bit #(
      .WIDTH(DATA_W)
   ) u_fifo1 (
      .clk      (clk),
      .rst      (rst),
      .push     (push1),
      .push_data(in_data),
      .pop      (pop1),
      .full     (full1),
      .empty    (empty1),
      .head     (out1_data)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt0_q <= '0;
         cnt1_q <= '0;
      end else begin
         if (push0) cnt0_q <= cnt0_q + cnt_t'(1);
         if (push1) cnt1_q <= cnt1_q + cnt_t'(1);
      end
   end

   assign out0_valid = !empty0;
   assign out1_valid = !empty1;
   assign cnt0       = cnt0_q;
   assign cnt1       = cnt1_q;

endmodule

// File: tb/tb_demux_1x2_16bit_buf.sv
// Self-checking bench: directed scenarios plus random traffic, compared against
// a queue-based reference model of the two destination buffers.
module tb_demux_1x2_16bit_buf;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] in_data;
   logic        in_sel;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] out0_data, out1_data;
   logic        out0_valid, out1_valid;
   logic        out0_ready, out1_ready;
   logic [15:0] cnt0, cnt1;

   int unsigned n_vec  = 0;
   int unsigned n_miss = 0;

   // Reference model: plain queues, last-seen heads, and counters.
   logic [15:0] mq0[$];
   logic [15:0] mq1[$];
   logic [15:0] h0 = '0, h1 = '0;
   logic [15:0] mc0 = '0, mc1 = '0;

   demux_1x2_16bit_buf dut (
      .clk       (clk),
      .rst       (rst),
      .in_data   (in_data),
      .in_sel    (in_sel),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out0_data (out0_data),
      .out0_valid(out0_valid),
      .out0_ready(out0_ready),
      .out1_data (out1_data),
      .out1_valid(out1_valid),
      .out1_ready(out1_ready),
      .cnt0      (cnt0),
      .cnt1      (cnt1)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp)
      else begin
         n_miss++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // One clock: drive inputs, check at the falling edge, advance the model.
   task automatic cycle(input logic r, input logic v, input logic s, input logic [15:0] d,
                        input logic rr0, input logic rr1);
      logic exp_rdy;
      rst = r; in_valid = v; in_sel = s; in_data = d; out0_ready = rr0; out1_ready = rr1;
      @(negedge clk);
      exp_rdy = !r && ((s ? mq1.size() : mq0.size()) < 2);
      chk("in_ready",   {31'b0, in_ready},   {31'b0, exp_rdy});
      chk("out0_valid", {31'b0, out0_valid}, {31'b0, (mq0.size() != 0)});
      chk("out1_valid", {31'b0, out1_valid}, {31'b0, (mq1.size() != 0)});
      chk("out0_data",  {16'b0, out0_data},  {16'b0, h0});
      chk("out1_data",  {16'b0, out1_data},  {16'b0, h1});
      chk("cnt0",       {16'b0, cnt0},       {16'b0, mc0});
      chk("cnt1",       {16'b0, cnt1},       {16'b0, mc1});
      if (r) begin
         mq0.delete(); mq1.delete();
         h0 = '0; h1 = '0; mc0 = '0; mc1 = '0;
      end else begin
         if (rr0 && mq0.size() != 0) void'(mq0.pop_front());
         if (rr1 && mq1.size() != 0) void'(mq1.pop_front());
         if (v && exp_rdy) begin
            if (s) begin mq1.push_back(d); mc1++; end
            else   begin mq0.push_back(d); mc0++; end
         end
         if (mq0.size() != 0) h0 = mq0[0];
         if (mq1.size() != 0) h1 = mq1[0];
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_sel = 1'b0; in_data = '0;
      out0_ready = 1'b0; out1_ready = 1'b0;
      @(posedge clk);
      #1;
      cycle(1, 1, 0, 16'h1111, 1, 1);                 // in_ready low during reset

      // Push ABCD to queue 0; visible the next cycle.
      cycle(0, 1, 0, 16'hABCD, 0, 0);
      cycle(0, 0, 0, 16'h0000, 0, 0);
      chk("abcd_data", {16'b0, out0_data}, 32'h0000_ABCD);
      chk("abcd_cnt0", {16'b0, cnt0}, 32'h1);

      // Fill queue 1, then check per-destination readiness.
      cycle(0, 1, 1, 16'h0088, 0, 0);
      cycle(0, 1, 1, 16'h1234, 0, 0);
      cycle(0, 1, 1, 16'hDEAD, 0, 0);                 // refused: queue 1 full
      chk("q1_full_rdy", {31'b0, in_ready}, 32'h0);
      cycle(0, 0, 0, 16'h0000, 0, 0);                 // sel=0 still ready
      cycle(0, 0, 1, 16'h0000, 0, 1);                 // pop 0088
      chk("q1_head2", {16'b0, out1_data}, 32'h0000_1234);
      cycle(0, 0, 1, 16'h0000, 0, 1);                 // pop 1234

      // Full queue 0: push refused even while popping.
      cycle(0, 1, 0, 16'h0088, 0, 0);
      cycle(0, 1, 0, 16'hBEEF, 1, 0);
      chk("q0_after_pop", {16'b0, out0_data}, 32'h0000_0088);
      // Occupancy 1: push and pop together replace the head.
      cycle(0, 1, 0, 16'h5555, 1, 0);
      chk("q0_replace", {16'b0, out0_data}, 32'h0000_5555);
      // Underflow: pop on an empty queue 1 is ignored.
      cycle(0, 1, 0, 16'h7777, 1, 1);
      cycle(0, 0, 0, 16'h0000, 0, 1);

      // Fill both, then reset with traffic offered.
      cycle(0, 1, 0, 16'h0101, 0, 0);
      cycle(0, 1, 1, 16'h0202, 0, 0);
      cycle(0, 1, 1, 16'h0303, 0, 0);
      cycle(1, 1, 0, 16'h0404, 1, 1);
      cycle(0, 1, 0, 16'h0505, 0, 0);                 // first push right after reset
      cycle(0, 0, 0, 16'h0000, 0, 0);

      // Random traffic.
      for (int i = 0; i < 3000; i++) begin
         cycle(($urandom_range(0, 99) == 0), $urandom_range(0, 1), $urandom_range(0, 1),
               16'($urandom), $urandom_range(0, 1), $urandom_range(0, 1));
      end

      // Counter wrap: 65535 accepted words, then one more.
      cycle(1, 0, 0, 16'h0000, 0, 0);
      for (int i = 0; i < 65535; i++) begin
         cycle(0, 1, 0, 16'(i), 1, 0);
      end
      cycle(0, 0, 0, 16'h0000, 0, 0);
      chk("cnt0_ffff", {16'b0, cnt0}, 32'h0000_FFFF);
      cycle(0, 1, 0, 16'hCAFE, 1, 0);
      cycle(0, 0, 0, 16'h0000, 0, 0);
      chk("cnt0_wrap", {16'b0, cnt0}, 32'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule

// File: doc/demux_1x2_16bit_buf.md
DEMUX_1X2_16BIT_BUF -- requirements
Module: demux_1x2_16bit_buf

Interface
REQ-001 SHALL have parameter DATA_W, default 16, width of routed data word.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port in_data  input  DATA_W  word to route.
REQ-005 SHALL have port in_sel  input  1  destination: 0 = out0, 1 = out1.
REQ-006 SHALL have port in_valid  input  1  upstream offers in_data/in_sel.
REQ-007 SHALL have port in_ready  output  1  block accepts the offered word this cycle.
REQ-008 SHALL have ports out0_data / out1_data  output  DATA_W  head word of each output queue.
REQ-009 SHALL have ports out0_valid / out1_valid  output  1  queue non-empty.
REQ-010 SHALL have ports out0_ready / out1_ready  input  1  downstream consumes head this cycle.
REQ-011 SHALL have ports cnt0 / cnt1  output  16  accepted-word count per destination.

Function
REQ-012 SHALL accept a word on a cycle with in_valid=1 and in_ready=1 (push), enqueuing in_data into queue in_sel.
REQ-013 SHALL provide one 2-entry FIFO per destination; per-queue order preserved; no cross-queue ordering is guaranteed.
REQ-014 SHALL drive in_ready = 1 iff queue[in_sel] holds fewer than 2 entries; in_ready depends only on in_sel and registered occupancy (no path from outN_ready).
REQ-015 SHALL pop queue N on a cycle with outN_valid=1 and outN_ready=1; outN_data then advances to next entry in the following cycle.
REQ-016 SHALL drive outN_valid = occupancy(N) != 0 and outN_data = head entry, both from registers (zero combinational input-to-output path).
REQ-017 Latency: word pushed in cycle T SHALL appear on outN_data with outN_valid=1 in cycle T+1 when queue N was empty.
REQ-018 Simultaneous push and pop on the same queue with occupancy 1 SHALL leave occupancy 1 with new head = pushed word.
REQ-019 Occupancy 2: push to that queue SHALL be refused (in_ready=0) even if the same cycle pops it.
REQ-020 Pop with occupancy 0 (outN_ready=1, outN_valid=0) SHALL be ignored; no underflow.
REQ-021 Push to one queue and pop from the other in the same cycle SHALL both complete independently.
REQ-022 in_sel changing while in_valid=1 and in_ready=0 SHALL re-evaluate in_ready against the new in_sel; the block does not latch in_sel before a push.
REQ-023 cntN SHALL increment by 1 on every push to queue N, wrapping 16'hFFFF -> 16'h0000.
REQ-024 outN_data SHALL hold its last value while outN_valid=0 (no X required, value unspecified to consumers).

Reset
REQ-025 On rst=1 at a rising edge: both occupancies = 0, read/write pointers = 0, out0_valid = out1_valid = 0, out0_data = out1_data = 0, cnt0 = cnt1 = 0.
REQ-026 During rst=1, in_ready SHALL be 0 and no push or pop SHALL take effect; in-flight queue contents are discarded.
REQ-027 First push SHALL be possible on the first cycle after rst deasserts.

Structure
REQ-028 DATA_W default (16) and queue depth (2) SHALL live in the shared processor definitions file, not as local literals.
REQ-029 SHALL instantiate sub-module fifo2_16bit twice (one per destination): push/pop/full/empty/head, sync active-high reset.
REQ-030 Top level SHALL contain only steering of push/pop, in_ready selection, and the two counters.

Verification
REQ-031 Reset then push 16'hABCD sel=0 -> next cycle out0_valid=1, out0_data=ABCD, out1_valid=0, cnt0=1.
REQ-032 Push 16'h0088 sel=1 with out1_ready=0, then push 16'h1234 sel=1 -> out1 queue full, in_ready=0 for sel=1 while in_ready=1 for sel=0; out1_data=0088 then 1234 after pops.
REQ-033 Queue 0 full (ABCD, 0088), out0_ready=1 and in_valid=1 sel=0 same cycle -> push refused, pop completes, occupancy 1, out0_data=0088.
REQ-034 Occupancy 1, simultaneous push 16'h5555 sel=0 and pop -> occupancy stays 1, out0_data=5555 next cycle.
REQ-035 Assert rst with both queues full -> next cycle all valids 0, cnt0=cnt1=0, in_ready=0 during rst, 1 afterward.
REQ-036 Preload cnt0 to 16'hFFFF via 65535 pushes/pops, push once more -> cnt0=16'h0000.
